sim_finisher_seq: RTL

Parametrised end-of-simulation sequencer for cosim benches. It collects one or more done flags from the DUT and injects a configurable trigger string into the kernel UART input using a full ready/valid handshake. It then watches the kernel UART output for a configurable terminator string and raises finished, pass or timed_out status. It sits in the bench top next to the SoC and replaces the single-character, always-ready finisher.

---
 rtl/sim_finisher_seq.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/sim_finisher_seq.sv
// rtl/sim_finisher_seq.sv - end-of-simulation sequencer: arm on done, send trigger string, match terminator string
// Optional console reporting and self-termination under SIM_FINISH_REPORT_EN.
module sim_finisher_seq #(
  parameter int                      NUM_DONE       = 1,
  parameter int                      DONE_ALL       = 0,
  parameter int                      TRIG_LEN       = 1,
  parameter logic [TRIG_LEN*8-1:0]   TRIG_STR       = 8'h72,
  parameter int                      TERM_LEN       = 1,
  parameter logic [TERM_LEN*8-1:0]   TERM_STR       = 8'h2e,
  parameter int                      TIMEOUT_CYCLES = 1000000,
  parameter int                      REPORT_W       = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_DONE-1:0] done,
  input  logic                success,
  input  logic [REPORT_W-1:0] report,
  input  logic [7:0]          kuart_from_cpu,
  input  logic                kuart_from_cpu_valid,
  output logic [7:0]          kuart_to_cpu,
  output logic                kuart_to_cpu_valid,
  input  logic                kuart_to_cpu_ready,
  output logic                finished,
  output logic                pass,
  output logic                timed_out
);

  localparam bit                TO_EN     = (TIMEOUT_CYCLES > 0);
  localparam int                CNT_W     = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [3:0]        TRIG_LAST = 4'(TRIG_LEN - 1);
  localparam logic [4:0]        TERM_FULL = 5'(TERM_LEN);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_TERM,
    FIN
  } state_t;

  state_t              state, state_nxt;
  logic [NUM_DONE-1:0] seen;
  logic                armed;
  logic [3:0]          tidx, tidx_nxt;
  logic [3:0]          midx, midx_nxt;
  logic [4:0]          midx_step;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                to_hit;
  logic                finished_nxt, pass_nxt, timed_out_nxt;

  // Strings unpacked into fixed 16-entry tables so a 4-bit index never exceeds the range.
  logic [7:0] trig_bytes [16];
  logic [7:0] term_bytes [16];

  for (genvar i = 0; i < 16; i++) begin : g_tables
    if (i < TRIG_LEN) begin : g_trig
      assign trig_bytes[i] = TRIG_STR[i*8 +: 8];
    end else begin : g_trig_pad
      assign trig_bytes[i] = 8'h00;
    end
    if (i < TERM_LEN) begin : g_term
      assign term_bytes[i] = TERM_STR[i*8 +: 8];
    end else begin : g_term_pad
      assign term_bytes[i] = 8'h00;
    end
  end

  assign armed              = (DONE_ALL != 0) ? &seen : |seen;
  assign kuart_to_cpu_valid = (state == SEND);
  assign kuart_to_cpu       = (state == SEND) ? trig_bytes[tidx] : 8'h00;
  assign to_hit             = TO_EN && (cnt == TO_LAST);

  // A mismatching byte may itself start a new match, hence the fallback to index 1.
  always_comb begin
    midx_step = 5'd0;
    if (kuart_from_cpu == term_bytes[midx]) begin
      midx_step = {1'b0, midx} + 5'd1;
    end else if (kuart_from_cpu == term_bytes[0]) begin
      midx_step = 5'd1;
    end
  end

  always_comb begin
    state_nxt     = state;
    tidx_nxt      = tidx;
    midx_nxt      = midx;
    cnt_nxt       = cnt;
    finished_nxt  = finished;
    pass_nxt      = pass;
    timed_out_nxt = timed_out;
    case (state)
      IDLE: begin
        if (armed) begin
          state_nxt = SEND;
          tidx_nxt  = 4'd0;
          midx_nxt  = 4'd0;
          cnt_nxt   = '0;
        end
      end
      SEND: begin
        if (TO_EN) cnt_nxt = cnt + CNT_W'(1);
        if (kuart_to_cpu_ready) begin
          if (tidx == TRIG_LAST) begin
            state_nxt = WAIT_TERM;
            midx_nxt  = 4'd0;
          end else begin
            tidx_nxt = tidx + 4'd1;
          end
        end
        if (to_hit) begin
          state_nxt     = FIN;
          finished_nxt  = 1'b1;
          pass_nxt      = 1'b0;
          timed_out_nxt = 1'b1;
        end
      end
      WAIT_TERM: begin
        if (TO_EN) cnt_nxt = cnt + CNT_W'(1);
        if (kuart_from_cpu_valid && (midx_step == TERM_FULL)) begin
          state_nxt     = FIN;
          finished_nxt  = 1'b1;
          pass_nxt      = success;
          timed_out_nxt = 1'b0;
        end else begin
          if (kuart_from_cpu_valid) midx_nxt = midx_step[3:0];
          if (to_hit) begin
            state_nxt     = FIN;
            finished_nxt  = 1'b1;
            pass_nxt      = 1'b0;
            timed_out_nxt = 1'b1;
          end
        end
      end
      FIN: begin
        state_nxt = FIN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      seen      <= '0;
      tidx      <= 4'd0;
      midx      <= 4'd0;
      cnt       <= '0;
      finished  <= 1'b0;
      pass      <= 1'b0;
      timed_out <= 1'b0;
    end else begin
      state     <= state_nxt;
      seen      <= seen | done;
      tidx      <= tidx_nxt;
      midx      <= midx_nxt;
      cnt       <= cnt_nxt;
      finished  <= finished_nxt;
      pass      <= pass_nxt;
      timed_out <= timed_out_nxt;
    end
  end

`ifdef SIM_FINISH_REPORT_EN
  logic [REPORT_W-1:0] report_q;

  always @(posedge clk) begin
    report_q <= report;
    if (report !== report_q) $display("Report update: %h", report);
    if (state == IDLE && state_nxt == SEND) $display("Sending finish trigger to kernel UART");
    if (state != FIN && state_nxt == FIN) begin
      if (timed_out_nxt) $display("Simulation TIMEOUT, report %h", report);
      else if (pass_nxt) $display("Simulation success, report %h", report);
      else $display("Simulation failure, report %h", report);
      $finish;
    end
  end
`else
  logic report_unused;
  assign report_unused = ^report;
`endif

endmodule
